frequency_meter: RTL and testbench
==================================

Name: frequency_meter

Overview:
- Measures an external digital signal by counting its rising edges over a gate window of programmable length, in `clk_in` cycles.
- Counterpart of the frequency divider: the divider turns a period value into a slow clock; this block turns a slow or unknown signal back into a count.
- Sits next to the 8-bit LED counter. The low byte of `count_out` can drive the board LEDs directly.

Parameters:
- GATE_WIDTH, 30, width of `gate_period` and of the internal gate counter.
- COUNT_WIDTH, 16, width of the edge counter and of `count_out`.

Ports:
- clk_in  input  1  system clock (50 MHz on board).
- rst_n_in  input  1  reset, asynchronous, active-low; one clock only.
- sig_in  input  1  signal under measurement; asynchronous to `clk_in`.
- en_in  input  1  measurement enable; level-sensitive.
- gate_period  input  GATE_WIDTH  gate window length in `clk_in` cycles; sampled at window start.
- count_out  output  COUNT_WIDTH  rising-edge count of the last completed window.
- valid_out  output  1  one-cycle pulse when `count_out` updates.
- overflow_out  output  1  high when the last completed window saturated.

Behaviour:
- Reset values:
  - `count_out` = 0, `valid_out` = 0, `overflow_out` = 0.
  - Sync chain and edge register = 0, gate counter = 0, edge counter = 0, state = IDLE.
  - Reset mid-window discards the window with no `valid_out`.
- Input path:
  - `sig_in` passes through 2 flip-flops (s1, s2), then an edge register s3.
  - edge = s2 & ~s3.
  - Latency from a `sig_in` rise to the edge being counted is 3 `clk_in` cycles.
  - `sig_in` held high across reset release produces exactly one counted edge.
- State IDLE:
  - Gate counter and edge counter are held at 0.
  - Outputs hold their last values; `valid_out` = 0.
  - `en_in` = 1 → latch gate_eff, go to MEASURE next cycle.
  - gate_eff = `gate_period`, except `gate_period` = 0 is treated as 1.
- State MEASURE:
  - The gate counter runs 0 .. gate_eff−1, one step per cycle; the window is exactly gate_eff cycles.
  - Each cycle with edge = 1 increments the edge counter.
  - The edge counter saturates at 2^COUNT_WIDTH−1 and sets an internal sat flag.
- Terminal cycle (gate counter = gate_eff−1), evaluated in that cycle:
  - total = edge counter + edge, saturating.
  - An edge in the terminal cycle belongs to the closing window.
  - On the next clock:
    - `count_out` ← total and `overflow_out` ← sat (including saturation caused by the terminal edge).
    - `valid_out` = 1 for one cycle.
    - Edge counter, gate counter and sat are cleared.
    - gate_eff is re-latched from `gate_period`.
  - Windows are back-to-back with no dead cycles.
  - With gate_eff = 1, every cycle is a terminal cycle, so `valid_out` stays high continuously.
- `en_in` falls during MEASURE:
  - Abort and go to IDLE on the next cycle.
  - No `valid_out`; `count_out` and `overflow_out` keep the last completed window.
  - If the abort cycle is also a terminal cycle, that window completes normally (`valid_out` pulses), then IDLE.
- `gate_period` changes mid-window have no effect until the next window start.
- All arithmetic is unsigned. The gate compare uses the full GATE_WIDTH bits, with no wrap.

Test Plan:
- Basic count: `gate_period` = 100, `sig_in` a square wave of period 10 `clk_in` cycles, `en_in` held 1 → from the second window on, `count_out` = 10 and `overflow_out` = 0, with `valid_out` pulsing exactly every 100 cycles.
- Saturation: COUNT_WIDTH overridden to 4, `gate_period` = 100, `sig_in` period 4 (25 edges) → `count_out` = 15, `overflow_out` = 1. Then slow `sig_in` to period 20 → next window `count_out` = 5, `overflow_out` = 0.
- Terminal-edge ownership: `gate_period` = 8, a single `sig_in` rise timed so its edge falls on gate counter = 7 → `count_out` = 1 for that window, 0 for the following window.
- Abort: `en_in` dropped at gate counter = 50 of a 100-cycle window → no `valid_out`, `count_out` keeps the previous value. Re-enable → a full 100-cycle window, then `valid_out`.
- Degenerate gate: `gate_period` = 0, `sig_in` held low → `valid_out` high every cycle with `count_out` = 0. A single rise → `count_out` = 1 for exactly one cycle.
- Async reset: assert `rst_n_in` = 0 mid-window for 3 cycles, with no `clk_in` edge during the low time → all outputs 0 immediately. After release with `en_in` = 1, the first `valid_out` comes gate_eff+1 cycles later.

Source files
------------

// File: rtl/frequency_meter.sv
// Counts rising edges of an asynchronous input over a programmable window of clk_in cycles.
// state   | meaning
// IDLE    | counters held at 0, outputs hold last window, waiting for en_in
// MEASURE | gate window running, edges accumulated; terminal cycle publishes result
module frequency_meter #(
    parameter int GATE_WIDTH  = 30,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   sig_in,
    input  logic                   en_in,
    input  logic [GATE_WIDTH-1:0]  gate_period,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic                   valid_out,
    output logic                   overflow_out
);

    typedef enum logic {
        ST_IDLE,
        ST_MEASURE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    logic                   s1_q, s1_d;
    logic                   s2_q, s2_d;
    logic                   s3_q, s3_d;
    logic [GATE_WIDTH-1:0]  gate_eff_q, gate_eff_d;
    logic [GATE_WIDTH-1:0]  gate_cnt_q, gate_cnt_d;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                   sat_q, sat_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    logic                   edge_det;
    logic                   terminal;
    logic                   cnt_at_max;
    logic [GATE_WIDTH-1:0]  gate_eff_load;
    logic [COUNT_WIDTH-1:0] total;
    logic                   sat_now;

    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;

        edge_det      = s2_q & ~s3_q;
        gate_eff_load = (gate_period == '0) ? GATE_WIDTH'(1) : gate_period;
        terminal      = (gate_cnt_q == (gate_eff_q - GATE_WIDTH'(1)));
        cnt_at_max    = (edge_cnt_q == CNT_MAX);
        total         = (edge_det && !cnt_at_max) ? edge_cnt_q + COUNT_WIDTH'(1) : edge_cnt_q;
        sat_now       = sat_q | (edge_det & cnt_at_max);

        state_d    = state_q;
        gate_eff_d = gate_eff_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (en_in) begin
                    gate_eff_d = gate_eff_load;
                    state_d    = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (terminal) begin
                    // an edge seen in the closing cycle belongs to this window
                    count_d    = total;
                    ovf_d      = sat_now;
                    valid_d    = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    gate_eff_d = gate_eff_load;
                    if (!en_in) begin
                        state_d = ST_IDLE;
                    end
                end else if (!en_in) begin
                    state_d    = ST_IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_WIDTH'(1);
                    edge_cnt_d = total;
                    sat_d      = sat_now;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            gate_eff_q <= GATE_WIDTH'(1);
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            gate_eff_q <= gate_eff_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign count_out    = count_q;
    assign valid_out    = valid_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: table of steady-state windows plus hand-timed corner sequences.
module tb_frequency_meter;

    logic        clk_in;
    logic        rst_n_in;
    logic        en_in;
    logic        sig_in;
    logic        sig_gen;
    logic        sig_man;
    logic        sig_auto;
    logic [29:0] gate_period;
    int          sig_half;

    logic [15:0] count_out;
    logic        valid_out;
    logic        overflow_out;
    logic [3:0]  count4;
    logic        valid4;
    logic        ovf4;

    int n_tests;
    int n_fail;

    assign sig_in = sig_auto ? sig_gen : sig_man;

    frequency_meter dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .sig_in      (sig_in),
        .en_in       (en_in),
        .gate_period (gate_period),
        .count_out   (count_out),
        .valid_out   (valid_out),
        .overflow_out(overflow_out)
    );

    frequency_meter #(.GATE_WIDTH(30), .COUNT_WIDTH(4)) dut4 (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .sig_in      (sig_in),
        .en_in       (en_in),
        .gate_period (gate_period),
        .count_out   (count4),
        .valid_out   (valid4),
        .overflow_out(ovf4)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // square wave of period 2*sig_half, toggled on the falling clock edge
    initial begin
        int cnt;
        cnt = 0;
        sig_gen = 1'b0;
        forever begin
            @(negedge clk_in);
            if (sig_half == 0) begin
                sig_gen = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= sig_half) begin
                    cnt = 0;
                    sig_gen = ~sig_gen;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, input int limit, output int ticks);
        ticks = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk_in);
            #1;
            ticks++;
            if (valid_out) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no valid_out, required one within %0d cycles", name, limit);
        ticks = -1;
    endtask

    typedef struct {
        int gate;
        int half;
        int cnt;
        int ovf;
        int cnt4;
        int ovf4;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int t;
        int seen_valid;

        n_tests     = 0;
        n_fail      = 0;
        rst_n_in    = 1'b0;
        en_in       = 1'b0;
        sig_auto    = 1'b0;
        sig_man     = 1'b0;
        sig_half    = 0;
        gate_period = 30'd100;

        tick(3);
        chk("rst_count", int'(count_out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_ovf", int'(overflow_out), 0);
        chk("rst_count4", int'(count4), 0);
        rst_n_in = 1'b1;
        tick(2);

        // gate, half period, main count/ovf, 4-bit count/ovf
        vecs[0] = '{100,  5, 10, 0, 10, 0};
        vecs[1] = '{100,  2, 25, 0, 15, 1};
        vecs[2] = '{100, 10,  5, 0,  5, 0};
        vecs[3] = '{ 64,  4,  8, 0,  8, 0};
        vecs[4] = '{ 40,  0,  0, 0,  0, 0};
        vecs[5] = '{ 36,  3,  6, 0,  6, 0};
        vecs[6] = '{1000, 1, 500, 0, 15, 1};
        vecs[7] = '{ 16,  1,  8, 0,  8, 0};

        sig_auto = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en_in       = 1'b0;
            gate_period = 30'(vecs[i].gate);
            sig_half    = vecs[i].half;
            tick(60);
            en_in = 1'b1;
            wait_valid($sformatf("v%0d_first", i), vecs[i].gate + 10, t);
            wait_valid($sformatf("v%0d_second", i), vecs[i].gate + 10, t);
            chk($sformatf("v%0d_interval", i), t, vecs[i].gate);
            chk($sformatf("v%0d_count", i), int'(count_out), vecs[i].cnt);
            chk($sformatf("v%0d_ovf", i), int'(overflow_out), vecs[i].ovf);
            chk($sformatf("v%0d_valid4", i), int'(valid4), 1);
            chk($sformatf("v%0d_count4", i), int'(count4), vecs[i].cnt4);
            chk($sformatf("v%0d_ovf4", i), int'(ovf4), vecs[i].ovf4);
            tick(1);
            chk($sformatf("v%0d_pulse", i), int'(valid_out), 0);
        end

        // terminal-edge ownership: single rise lands on gate counter 7 of an 8-cycle window
        en_in       = 1'b0;
        sig_auto    = 1'b0;
        sig_man     = 1'b0;
        gate_period = 30'd8;
        tick(10);
        en_in = 1'b1;
        tick(6);
        sig_man = 1'b1;
        tick(3);
        chk("term_valid", int'(valid_out), 1);
        chk("term_count", int'(count_out), 1);
        tick(1);
        chk("term_pulse", int'(valid_out), 0);
        tick(7);
        chk("term_next_valid", int'(valid_out), 1);
        chk("term_next_count", int'(count_out), 0);

        // degenerate gate: every cycle is terminal
        en_in       = 1'b0;
        sig_man     = 1'b0;
        gate_period = 30'd0;
        tick(10);
        en_in = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk($sformatf("deg_valid%0d", i), int'(valid_out), 1);
            chk($sformatf("deg_count%0d", i), int'(count_out), 0);
        end
        sig_man = 1'b1;
        tick(2);
        chk("deg_before_edge", int'(count_out), 0);
        tick(1);
        chk("deg_edge_count", int'(count_out), 1);
        chk("deg_edge_valid", int'(valid_out), 1);
        tick(1);
        chk("deg_after_edge", int'(count_out), 0);
        chk("deg_after_valid", int'(valid_out), 1);

        // abort at gate counter 50 of a 100-cycle window
        en_in       = 1'b0;
        sig_auto    = 1'b1;
        sig_half    = 5;
        gate_period = 30'd100;
        tick(60);
        en_in = 1'b1;
        wait_valid("abort_warm1", 110, t);
        wait_valid("abort_warm2", 110, t);
        chk("abort_pre_count", int'(count_out), 10);
        tick(50);
        en_in = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (valid_out) seen_valid = 1;
        end
        chk("abort_no_valid", seen_valid, 0);
        chk("abort_keep_count", int'(count_out), 10);
        en_in = 1'b1;
        wait_valid("abort_restart", 200, t);
        chk("abort_restart_latency", t, 101);
        chk("abort_restart_count", int'(count_out), 10);

        // asynchronous reset mid-window
        wait_valid("rst_warm", 110, t);
        tick(30);
        rst_n_in = 1'b0;
        #1;
        chk("arst_count", int'(count_out), 0);
        chk("arst_valid", int'(valid_out), 0);
        chk("arst_ovf", int'(overflow_out), 0);
        chk("arst_count4", int'(count4), 0);
        tick(3);
        chk("arst_hold_count", int'(count_out), 0);
        rst_n_in = 1'b1;
        wait_valid("arst_first", 200, t);
        chk("arst_first_latency", t, 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
